calendar_keeper: RTL

Parametrised calendar counter that keeps day, month, year and weekday, advancing once per `day_tick` pulse from the time-keeping block. It applies the full Gregorian leap rule (÷4, ÷100, ÷400) on an offset year (`YEAR_BASE + year`). It also supports validated date loads through a sequential modulo-400 engine. Sits between the hour/minute counter (tick source) and the display/alarm logic (consumers of `date_out`, `wday`, pulses).

---
 rtl/calendar_keeper_if.sv | 26 ++
 rtl/calendar_keeper.sv | 132 +++++++++++++
 2 files changed

// File: rtl/calendar_keeper_if.sv
// calendar_keeper_if: bundle of tick/load requests and committed-date/status signals for calendar_keeper
// master drives day_tick, load, date_in, wday_in and observes results; slave is the calendar itself.
interface calendar_keeper_if #(
    parameter int YEAR_W = 12
);
    logic              day_tick;
    logic              load;
    logic [YEAR_W+8:0] date_in;
    logic [2:0]        wday_in;
    logic [YEAR_W+8:0] date_out;
    logic [2:0]        wday;
    logic              leap;
    logic              busy;
    logic              load_ok;
    logic              load_err;
    logic              new_month;
    logic              new_year;
    modport master (
        output day_tick, load, date_in, wday_in,
        input  date_out, wday, leap, busy, load_ok, load_err, new_month, new_year
    );
    modport slave (
        input  day_tick, load, date_in, wday_in,
        output date_out, wday, leap, busy, load_ok, load_err, new_month, new_year
    );
endinterface

// File: rtl/calendar_keeper.sv
// calendar_keeper: Gregorian day/month/year/weekday counter with validated loads via a sequential mod-400 engine
// Ports: clk; rst_n (async, active-low); bus (slave): day_tick, load, date_in {day,month,year}, wday_in in;
//        date_out, wday, leap, busy, load_ok, load_err, new_month, new_year out.
module calendar_keeper #(
    parameter int YEAR_W    = 12,
    parameter int YEAR_BASE = 0,
    parameter int RST_DAY   = 1,
    parameter int RST_MONTH = 1,
    parameter int RST_YEAR  = 0,
    parameter int RST_WDAY  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    calendar_keeper_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, CHECK} state_t;
    localparam logic [8:0]        Y400_RST  = 9'((YEAR_BASE + RST_YEAR) % 400);
    localparam logic [8:0]        Y400_WRAP = 9'(YEAR_BASE % 400);
    localparam logic [YEAR_W:0]   R400      = (YEAR_W + 1)'(400);
    localparam logic [YEAR_W:0]   R_BASE    = (YEAR_W + 1)'(YEAR_BASE);
    localparam logic [YEAR_W-1:0] Y_ONE     = YEAR_W'(1);
    localparam logic [YEAR_W-1:0] Y_MAX     = '1;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        return (m == 4'd2) ? (lp ? 5'd29 : 5'd28) :
               (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    function automatic logic is_leap(input logic [8:0] y);
        return y[1:0] == 2'd0 && y != 9'd100 && y != 9'd200 && y != 9'd300;
    endfunction

    state_t            state, state_nx;
    logic [4:0]        day, st_day;
    logic [3:0]        month, st_month;
    logic [YEAR_W-1:0] year, st_year;
    logic [2:0]        wd, st_wd;
    logic [8:0]        y400, y400_stage;
    logic [YEAR_W:0]   rem;
    logic              ok_q, err_q, nm_q, ny_q;
    logic              leap, accept, calc_sub, calc_end, st_valid, commit, reject, tick, last_day, last_month;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (bus.load ? CALC : IDLE) :
                   (state == CALC) ? ((rem < R400) ? CHECK : CALC) : IDLE;
    end

    always_comb begin
        leap       = is_leap(y400);
        accept     = state == IDLE && bus.load;
        calc_sub   = state == CALC && rem >= R400;
        calc_end   = state == CALC && rem < R400;
        st_valid   = st_month >= 4'd1 && st_month <= 4'd12 && st_day >= 5'd1 &&
                     st_day <= month_len(st_month, is_leap(y400_stage));
        commit     = state == CHECK && st_valid;
        reject     = state == CHECK && !st_valid;
        // The commit edge owns the committed registers, so a tick there is dropped.
        tick       = bus.day_tick && state != CHECK;
        last_day   = day == month_len(month, leap);
        last_month = month == 4'd12;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day        <= 5'(RST_DAY);
            month      <= 4'(RST_MONTH);
            year       <= YEAR_W'(RST_YEAR);
            wd         <= 3'(RST_WDAY);
            y400       <= Y400_RST;
            st_day     <= '0;
            st_month   <= '0;
            st_year    <= '0;
            st_wd      <= '0;
            rem        <= '0;
            y400_stage <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            nm_q       <= 1'b0;
            ny_q       <= 1'b0;
        end else begin
            ok_q  <= commit;
            err_q <= reject;
            nm_q  <= tick && last_day;
            ny_q  <= tick && last_day && last_month;
            if (commit) begin
                day   <= st_day;
                month <= st_month;
                year  <= st_year;
                wd    <= st_wd;
                y400  <= y400_stage;
            end else if (tick) begin
                wd <= (wd == 3'd6) ? 3'd0 : wd + 3'd1;
                if (!last_day) begin
                    day <= day + 5'd1;
                end else begin
                    day <= 5'd1;
                    if (last_month) begin
                        month <= 4'd1;
                        year  <= (year == Y_MAX) ? '0 : year + Y_ONE;
                        y400  <= (year == Y_MAX) ? Y400_WRAP : (y400 == 9'd399) ? 9'd0 : y400 + 9'd1;
                    end else begin
                        month <= month + 4'd1;
                    end
                end
            end
            if (accept) begin
                st_day   <= bus.date_in[YEAR_W+8:YEAR_W+4];
                st_month <= bus.date_in[YEAR_W+3:YEAR_W];
                st_year  <= bus.date_in[YEAR_W-1:0];
                st_wd    <= bus.wday_in;
                rem      <= R_BASE + {1'b0, bus.date_in[YEAR_W-1:0]};
            end else if (calc_sub) begin
                rem <= rem - R400;
            end
            if (calc_end) y400_stage <= rem[8:0];
        end
    end

    assign bus.date_out  = {day, month, year};
    assign bus.wday      = wd;
    assign bus.leap      = leap;
    assign bus.busy      = state != IDLE;
    assign bus.load_ok   = ok_q;
    assign bus.load_err  = err_q;
    assign bus.new_month = nm_q;
    assign bus.new_year  = ny_q;
endmodule
